// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display sequencer.
//   state_t         RUN / PAUSE / STEP operating state (2-bit encoding)
//   SPEED_W         width of the speed selector (increment = 1 << 4*speed)
//   *_HI / *_LO     counter bit taps routed to each display input
package display_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2
  } state_t;

  localparam int SPEED_W = 2;

  localparam int RED_HI = 31;
  localparam int RED_LO = 16;
  localparam int GRN_HI = 30;
  localparam int GRN_LO = 15;
  localparam int SEG_HI = 47;
  localparam int SEG_LO = 16;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises one raw active-low push-button into clk,
// debounces it and emits a one-cycle pulse on each accepted press.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   key_n  in   raw button, active-low, asynchronous to clk
//   press  out  one-cycle pulse, 2 + DEBOUNCE_CYCLES + 1 cycles after a stable low
// DEBOUNCE_CYCLES must be at least 3 so the synchroniser's reset fill cannot
// be mistaken for a genuine release (see the arming logic below).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 740000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic          level_prev;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          cnt_done;

  assign cnt_done = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b1;
      sync       <= 1'b1;
      level      <= 1'b1;
      level_prev <= 1'b1;
      armed      <= 1'b0;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      // synchroniser stage
      meta       <= key_n;
      sync       <= meta;
      // edge-detect stage
      level_prev <= level;
      press      <= armed & level_prev & ~level;
      // After reset the key must be seen released for a full debounce window
      // before presses are accepted, so a key held through reset is ignored.
      if (!armed) begin
        if (sync) begin
          if (cnt_done) begin
            armed <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end else if (sync != level) begin
        if (cnt_done) begin
          level <= sync;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// display_ctrl: owns the display counter and sequences what the LED /
// 7-segment display shows, under control of two debounced push-buttons.
//   clk_video    in   video clock (only clock)
//   reset_n      in   asynchronous active-low reset
//   key_mode_n   in   raw mode button (RUN <-> PAUSE), active-low
//   key_step_n   in   raw step/speed button, active-low
//   frame_start  in   one-cycle pulse at the first pixel of each frame
//   red_leds     out  frame-latched counter[31:16]
//   green_leds   out  frame-latched counter[30:15]
//   segments     out  frame-latched counter[47:16]
//   status       out  {state, speed, 3'b0, heartbeat}, live
module display_ctrl
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 740000,
  parameter int CNT_W           = 48
) (
  input  logic        clk_video,
  input  logic        reset_n,
  input  logic        key_mode_n,
  input  logic        key_step_n,
  input  logic        frame_start,
  output logic [15:0] red_leds,
  output logic [15:0] green_leds,
  output logic [31:0] segments,
  output logic [7:0]  status
);

  state_t             state;
  logic [SPEED_W-1:0] speed;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   inc;
  logic               heartbeat;
  logic               mode_press;
  logic               step_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk_video),
    .rst_n (reset_n),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk   (clk_video),
    .rst_n (reset_n),
    .key_n (key_step_n),
    .press (step_press)
  );

  // Each speed step multiplies the increment by 16: 1, 16, 256, 4096.
  always_comb begin
    inc = {{(CNT_W-1){1'b0}}, 1'b1} << {speed, 2'b00};
  end

  // Mode press is checked first so it wins over a simultaneous step press.
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_RUN;
      speed   <= '0;
      counter <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          counter <= counter + inc;
          if (mode_press) begin
            state <= ST_PAUSE;
          end else if (step_press) begin
            speed <= speed + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (mode_press) begin
            state <= ST_RUN;
          end else if (step_press) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          counter <= counter + inc;
          state   <= ST_PAUSE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // frame latch stage: outputs only change at a frame boundary, never mid-frame
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      red_leds   <= '0;
      green_leds <= '0;
      segments   <= '0;
      heartbeat  <= 1'b0;
    end else if (frame_start) begin
      red_leds   <= counter[RED_HI:RED_LO];
      green_leds <= counter[GRN_HI:GRN_LO];
      segments   <= counter[SEG_HI:SEG_LO];
      heartbeat  <= ~heartbeat;
    end
  end

  assign status = {state, speed, 3'b000, heartbeat};

endmodule

// File: tb/tb_display_ctrl.sv
// tb_display_ctrl: directed self-checking bench for display_ctrl with a
// short debounce window (4 cycles) and a frame pulse every 100 cycles,
// the first one 50 cycles after reset release.
module tb_display_ctrl;
  import display_pkg::*;

  logic        clk_video = 1'b0;
  logic        reset_n;
  logic        key_mode_n;
  logic        key_step_n;
  logic        frame_start;
  logic [15:0] red_leds;
  logic [15:0] green_leds;
  logic [31:0] segments;
  logic [7:0]  status;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk_video = ~clk_video;

  display_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(48)) dut (
    .clk_video   (clk_video),
    .reset_n     (reset_n),
    .key_mode_n  (key_mode_n),
    .key_step_n  (key_step_n),
    .frame_start (frame_start),
    .red_leds    (red_leds),
    .green_leds  (green_leds),
    .segments    (segments),
    .status      (status)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and schedule frame_start for the
  // following rising edge.
  task automatic tick();
    @(negedge clk_video);
    if (reset_n) begin
      cyc++;
      frame_start = ((cyc % 100) == 50);
    end else begin
      cyc = 0;
      frame_start = 1'b0;
    end
  endtask

  // Hold the selected key(s) low for 8 cycles, report state after 7, 8 and
  // 9 cycles and the counter after 8, then wait out the release debounce.
  task automatic press(input bit mode, input bit step,
                       output logic [1:0] st7, output logic [1:0] st8,
                       output logic [1:0] st9, output logic [47:0] cnt8);
    if (mode) key_mode_n = 1'b0;
    if (step) key_step_n = 1'b0;
    repeat (7) tick();
    st7 = status[7:6];
    tick();
    st8  = status[7:6];
    cnt8 = dut.counter;
    key_mode_n = 1'b1;
    key_step_n = 1'b1;
    tick();
    st9 = status[7:6];
    repeat (10) tick();
  endtask

  initial begin
    logic [1:0]  s7, s8, s9;
    logic [47:0] c8, c0, frozen;
    bit          saw;
    int          n;

    reset_n     = 1'b0;
    key_mode_n  = 1'b1;
    key_step_n  = 1'b1;
    frame_start = 1'b0;
    tick();
    tick();
    check("rst_status", status, 8'h00);
    check("rst_red", red_leds, 16'h0);
    check("rst_green", green_leds, 16'h0);
    check("rst_segments", segments, 32'h0);
    // frame pulse while in reset must not toggle the heartbeat
    frame_start = 1'b1;
    @(negedge clk_video);
    frame_start = 1'b0;
    check("rst_frame_ignored", status, 8'h00);

    // ---- free run after reset release
    reset_n = 1'b1;
    repeat (10) tick();
    check("run_count10", dut.counter, 48'd10);
    while (cyc < 50) tick();
    check("status_pre_frame", status, 8'h00);
    tick();
    check("status_post_frame", status, 8'h01);
    check("seg_first_frame", segments, 32'h0);
    check("red_first_frame", red_leds, 16'h0);

    // ---- mode press: RUN -> PAUSE with exact latency, counter frozen
    press(1'b1, 1'b0, s7, s8, s9, c8);
    check("mode_lat_7", s7, ST_RUN);
    check("mode_lat_8", s8, ST_PAUSE);
    frozen = dut.counter;
    repeat (5) tick();
    check("pause_frozen", dut.counter, frozen);
    press(1'b1, 1'b0, s7, s8, s9, c8);
    check("resume_run", s8, ST_RUN);
    check("resume_from_frozen", c8, frozen);
    c0 = dut.counter;
    repeat (5) tick();
    check("resume_counting", dut.counter, c0 + 48'd5);

    // ---- single steps from PAUSE
    press(1'b1, 1'b0, s7, s8, s9, c8);
    check("to_pause", s8, ST_PAUSE);
    c0 = dut.counter;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b1, s7, s8, s9, c8);
      check("step_state", s8, ST_STEP);
      check("step_back_pause", s9, ST_PAUSE);
    end
    check("step_plus3", dut.counter, c0 + 48'd3);

    // ---- speed 2 in RUN: +256 per cycle
    press(1'b1, 1'b0, s7, s8, s9, c8);
    press(1'b0, 1'b1, s7, s8, s9, c8);
    press(1'b0, 1'b1, s7, s8, s9, c8);
    check("speed2_state", status[7:4], 4'b0010);
    c0 = dut.counter;
    repeat (4) tick();
    check("speed2_rate", dut.counter, c0 + 48'd1024);

    // ---- bouncing step key produces no press
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_step_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        tick();
        if (dut.step_press) saw = 1'b1;
      end
    end
    key_step_n = 1'b1;
    repeat (10) begin
      tick();
      if (dut.step_press) saw = 1'b1;
    end
    check("bounce_no_press", saw, 1'b0);
    check("bounce_state_speed", status[7:4], 4'b0010);

    // ---- simultaneous presses: mode wins
    press(1'b1, 1'b1, s7, s8, s9, c8);
    check("both_state", s8, ST_PAUSE);
    check("both_speed", status[5:4], 2'd2);

    // ---- frame latch slices with a known counter value (held in PAUSE)
    force dut.counter = 48'h1234_5678_9ABC;
    #1 release dut.counter;
    repeat (3) tick();
    check("latch_hold", dut.counter, 48'h1234_5678_9ABC);
    n = 0;
    while (!frame_start && n < 200) begin
      tick();
      n++;
    end
    check("frame_wait_bound", (n < 200), 1'b1);
    tick();
    check("latch_red", red_leds, 16'h5678);
    check("latch_green", green_leds, 16'hACF1);
    check("latch_segments", segments, 32'h1234_5678);

    // ---- reset, then wrap from 2^48-2
    reset_n = 1'b0;
    #1;
    check("rst2_red", red_leds, 16'h0);
    check("rst2_green", green_leds, 16'h0);
    check("rst2_segments", segments, 32'h0);
    check("rst2_status", status, 8'h00);
    tick();
    reset_n = 1'b1;
    force dut.counter = 48'hFFFF_FFFF_FFFE;
    #1 release dut.counter;
    repeat (3) tick();
    check("wrap_to_1", dut.counter, 48'd1);

    // ---- reset pulse while mode key is held: no press on deassertion
    key_mode_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("rst3_outputs", {red_leds, green_leds, segments, status}, 72'h0);
    tick();
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (status[7:6] != ST_RUN) saw = 1'b1;
    end
    check("held_key_no_pause", saw, 1'b0);
    key_mode_n = 1'b1;
    repeat (10) tick();
    press(1'b1, 1'b0, s7, s8, s9, c8);
    check("repress_pause", s8, ST_PAUSE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_ctrl.md
Name: display_ctrl

Overview:
- Sequences the content shown by the HDMI LED/7-segment display: it owns the 48-bit display counter and drives the display's red_leds, green_leds and segments inputs.
- Raw push-buttons are synchronised and debounced. A RUN/PAUSE/STEP state machine selects between free-running counting, a frozen display and single-step increments, with a selectable speed.
- Display outputs update only on a frame-start pulse, so the picture never tears mid-frame.
- Sits between the board keys and the display instance, in the clk_video domain.

Parameters:
- DEBOUNCE_CYCLES, 740000, cycles a synchronised key level must stay stable before it is accepted (10 ms at 74 MHz).
- CNT_W, 48, display counter width; minimum 48.

Ports:
- clk_video  in  1  video clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- key_mode_n  in  1  raw mode button, active-low, asynchronous to clk_video.
- key_step_n  in  1  raw step/speed button, active-low, asynchronous.
- frame_start  in  1  one-cycle pulse from the display at the first pixel of each frame.
- red_leds  out  16  frame-latched counter[31:16].
- green_leds  out  16  frame-latched counter[30:15].
- segments  out  32  frame-latched counter[47:16].
- status  out  8  {state[1:0], speed[1:0], 3'b0, heartbeat}; drives board LEDs live, not frame-latched.

Behaviour:
- Reset (asynchronous, reset_n low):
  - counter = 0, state = RUN, speed = 0, debounce counters = 0.
  - Synchronisers and debounced levels = 1 (released).
  - red_leds, green_leds, segments and status = 0.
- Input path: 2-flop synchroniser per key, then debounce.
  - Debounced level changes after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back restarts the count.
- Press event: one-cycle pulse on a debounced 1->0 edge. Release generates nothing.
- Total key latency: 2 + DEBOUNCE_CYCLES + 1 cycles from a stable raw low to the press pulse.
- States (state encoding RUN=0, PAUSE=1, STEP=2):
  - RUN: counter += inc every cycle, where inc = 1 << (4*speed), i.e. 1, 16, 256 or 4096.
    - mode press -> PAUSE.
    - step press -> speed = speed+1, wrapping 3->0. State stays RUN.
  - PAUSE: counter holds.
    - mode press -> RUN.
    - step press -> STEP.
  - STEP: counter += inc for exactly one cycle, then unconditionally -> PAUSE. Presses arriving in this cycle are ignored.
- Simultaneous mode and step presses in the same cycle: mode wins and step is dropped.
- Counter arithmetic: modulo 2^CNT_W. All-ones + inc wraps silently, with no sticky flag.
- Frame latch: on frame_start, red_leds/green_leds/segments capture slices of the counter value present in that cycle. The value is visible the next cycle and holds until the next frame_start.
  - Until the first frame_start after reset the outputs stay 0.
  - frame_start asserted during reset is ignored.
- heartbeat: toggles on every frame_start, giving a visible frame-rate/2 blink.
- Reset mid-operation: all state returns to reset values immediately. Press events in flight are lost, and no press is generated on deassertion even if a key is held; a held key must be released and pressed again.

Decomposition:
- Shared package display_pkg holds:
  - state enum (RUN, PAUSE, STEP);
  - speed width constant SPEED_W = 2;
  - slice-position constants for the red/green/segments taps (31:16, 30:15, 47:16).
- One natural sub-module, key_debounce: synchroniser, debounce counter and press-pulse generator, parameterised by DEBOUNCE_CYCLES. It is instantiated twice.
- The FSM, counter and frame latch stay in display_ctrl.

Test Plan (bench uses DEBOUNCE_CYCLES=4, frame_start every 100 cycles):
- Reset release, no keys: counter increments by 1 per cycle. At the first frame_start, issued 50 cycles after reset release, segments = counter[47:16] = 0 and red_leds = 0. status = 0x00 before the first frame_start and 0x01 after it.
- Mode key held low for 8 cycles: state becomes PAUSE exactly 7 cycles after the first low sample, and the counter freezes. A second press returns to RUN and counting resumes from the frozen value.
- In PAUSE, three step presses: counter increases by exactly 3, and state passes through STEP for one cycle each time. Then in RUN with speed already 2 via two step presses: counter advances by 256 per cycle.
- Bouncing key: raw step toggles every 2 cycles for 20 cycles, then stays high. No press event occurs and state/speed are unchanged.
- Both keys pressed with identical timing while in RUN: state becomes PAUSE and speed is unchanged.
- Counter preloaded by force to 2^48-2, speed 0, RUN: after 3 cycles counter = 1. reset_n asserted for 1 cycle mid-run while the mode key is held: all outputs return to 0, and no PAUSE occurs after release until the key is re-pressed.
